// File: rtl/rect_fill_pkg.sv
// Shared frame-buffer constants and FSM state encoding for the rectangle-fill engine.
package rect_fill_pkg;

  localparam int unsigned WIDTH  = 640;
  localparam int unsigned HEIGHT = 480;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned PIX_W  = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLIP = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rect_fill_clip.sv
// rect_clip: combinational screen-edge clipping of a latched rectangle command.
module rect_clip
  import rect_fill_pkg::*;
#(
  parameter int unsigned H_RES = WIDTH,
  parameter int unsigned V_RES = HEIGHT
) (
  input  logic [9:0]  x0,
  input  logic [8:0]  y0,
  input  logic [9:0]  w,
  input  logic [8:0]  h,
  output logic [10:0] x_end,
  output logic [9:0]  y_end,
  output logic        empty
);

  logic [10:0] x_sum;
  logic [9:0]  y_sum;

  // Sums are one bit wider than the operands so x0+w / y0+h never wrap.
  always_comb begin
    x_sum = {1'b0, x0} + {1'b0, w};
    y_sum = {1'b0, y0} + {1'b0, h};
    x_end = (x_sum > 11'(H_RES)) ? 11'(H_RES) : x_sum;
    y_end = (y_sum > 10'(V_RES)) ? 10'(V_RES) : y_sum;
    empty = (w == '0) || (h == '0) ||
            ({1'b0, x0} >= 11'(H_RES)) || ({1'b0, y0} >= 10'(V_RES));
  end

endmodule

// File: rtl/rect_fill.sv
// Rectangle-fill engine: streams one clipped VROM write per clock for each start command.
// Perimeter-only drawing is compiled in with RECT_FILL_OUTLINE_EN.
module rect_fill
  import rect_fill_pkg::*;
#(
  parameter int unsigned H_RES = WIDTH,
  parameter int unsigned V_RES = HEIGHT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [9:0]          x0,
  input  logic [8:0]          y0,
  input  logic [9:0]          w,
  input  logic [8:0]          h,
  input  logic [PIX_W-1:0]    color,
  input  logic                outline,
  output logic                we,
  output logic [ADDR_W-1:0]   addr,
  output logic [PIX_W-1:0]    dout,
  output logic                busy,
  output logic                done
);

  state_t state_q, state_n;

  logic [9:0]        x0_q, w_q, x_q, x_n;
  logic [8:0]        y0_q, h_q, y_q, y_n;
  logic [PIX_W-1:0]  color_q;
  logic [ADDR_W-1:0] row_q, row_n, addr_n, dout_unused_base;
  logic [PIX_W-1:0]  dout_n;
  logic              we_n, busy_n, done_n, load;
  logic              pix_en;

  logic [10:0] x_end;
  logic [9:0]  y_end;
  logic        empty;
  logic        x_last, y_last;

`ifdef RECT_FILL_OUTLINE_EN
  logic outline_q;
`else
  logic outline_unused;
  assign outline_unused = outline;
`endif

  rect_clip #(.H_RES(H_RES), .V_RES(V_RES)) u_clip (
    .x0    (x0_q),
    .y0    (y0_q),
    .w     (w_q),
    .h     (h_q),
    .x_end (x_end),
    .y_end (y_end),
    .empty (empty)
  );

  assign x_last = (({1'b0, x_q} + 11'd1) == x_end);
  assign y_last = (({1'b0, y_q} + 10'd1) == y_end);
  assign dout_unused_base = ADDR_W'(y0_q) * ADDR_W'(H_RES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    load    = 1'b0;
    we_n    = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    addr_n  = addr;
    dout_n  = dout;
    x_n     = x_q;
    y_n     = y_q;
    row_n   = row_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          busy_n  = 1'b1;
          state_n = CLIP;
        end
      end
      CLIP: begin
        if (empty) begin
          state_n = DONE;
        end else begin
          busy_n  = 1'b1;
          x_n     = x0_q;
          y_n     = y0_q;
          row_n   = dout_unused_base;
          state_n = FILL;
        end
      end
      FILL: begin
        if (x_last && y_last) begin
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          busy_n = 1'b1;
          if (x_last) begin
            x_n   = x0_q;
            y_n   = y_q + 9'd1;
            row_n = row_q + ADDR_W'(H_RES);
          end else begin
            x_n = x_q + 10'd1;
          end
        end
      end
      DONE: begin
        // An empty command enters DONE with done low; raise it here so the pulse lands one edge later.
        if (done) state_n = IDLE;
        else      done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    pix_en = 1'b1;
`ifdef RECT_FILL_OUTLINE_EN
    if (outline_q) begin
      pix_en = (x_n == x0_q) || (y_n == y0_q) ||
               ({1'b0, x_n} == ({1'b0, x0_q} + {1'b0, w_q} - 11'd1)) ||
               ({1'b0, y_n} == ({1'b0, y0_q} + {1'b0, h_q} - 10'd1));
    end
`endif

    if (busy_n && (state_n == FILL)) begin
      we_n   = pix_en;
      addr_n = row_n + ADDR_W'(x_n);
      dout_n = color_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      row_q   <= '0;
      we      <= 1'b0;
      addr    <= '0;
      dout    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef RECT_FILL_OUTLINE_EN
      outline_q <= 1'b0;
`endif
    end else begin
      if (load) begin
        x0_q    <= x0;
        y0_q    <= y0;
        w_q     <= w;
        h_q     <= h;
        color_q <= color;
`ifdef RECT_FILL_OUTLINE_EN
        outline_q <= outline;
`endif
      end
      x_q   <= x_n;
      y_q   <= y_n;
      row_q <= row_n;
      we    <= we_n;
      addr  <= addr_n;
      dout  <= dout_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_rect_fill.sv
// Directed self-checking bench for rect_fill; outline expectations follow RECT_FILL_OUTLINE_EN.
module tb_rect_fill;

  logic        clk = 1'b0;
  logic        rst, start, outline;
  logic [9:0]  x0, w;
  logic [8:0]  y0, h;
  logic [11:0] color;
  logic        we, busy, done;
  logic [18:0] addr;
  logic [11:0] dout;

  int checks = 0;
  int passes = 0;

  logic [18:0] wa[$];
  logic [11:0] wd[$];
  int          done_cyc;
  logic        busy0;

  always #5 clk = ~clk;

  rect_fill #(.H_RES(640), .V_RES(480)) dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
    .color(color), .outline(outline), .we(we), .addr(addr), .dout(dout),
    .busy(busy), .done(done)
  );

  // Issues one command and records writes until done (bounded); makes no comparisons itself.
  task automatic run_cmd(input logic [9:0] cx, input logic [8:0] cy, input logic [9:0] cw,
                         input logic [8:0] ch, input logic [11:0] cc, input logic co);
    wa.delete();
    wd.delete();
    done_cyc = -1;
    @(negedge clk);
    x0 = cx; y0 = cy; w = cw; h = ch; color = cc; outline = co; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy0 = busy;
    x0 = ~cx; y0 = ~cy; w = ~cw; h = ~ch; color = ~cc; outline = ~co;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (we) begin
        wa.push_back(addr);
        wd.push_back(dout);
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; outline = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (we !== 1'b0) $display("FAIL reset_we got=%b exp=0", we); else passes++;
    checks++; if (addr !== 19'd0) $display("FAIL reset_addr got=%0d exp=0", addr); else passes++;
    checks++; if (dout !== 12'd0) $display("FAIL reset_dout got=%h exp=000", dout); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passes++;
  endtask

  task automatic test_basic();
    logic [18:0] ea [6] = '{19'd12810, 19'd12811, 19'd12812, 19'd13450, 19'd13451, 19'd13452};
    run_cmd(10'd10, 9'd20, 10'd3, 9'd2, 12'hF00, 1'b0);
    checks++; if (busy0 !== 1'b1) $display("FAIL basic_busy_edge0 got=%b exp=1", busy0); else passes++;
    checks++; if (wa.size() != 6) $display("FAIL basic_count got=%0d exp=6", wa.size()); else passes++;
    for (int i = 0; i < 6 && i < wa.size(); i++) begin
      checks++; if (wa[i] !== ea[i]) $display("FAIL basic_addr[%0d] got=%0d exp=%0d", i, wa[i], ea[i]); else passes++;
      checks++; if (wd[i] !== 12'hF00) $display("FAIL basic_dout[%0d] got=%h exp=F00", i, wd[i]); else passes++;
    end
    checks++; if (done_cyc != 7) $display("FAIL basic_done_cycle got=%0d exp=7", done_cyc); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done got=%b exp=0", busy); else passes++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse got=%b exp=0", done); else passes++;
  endtask

  task automatic test_clip();
    run_cmd(10'd638, 9'd479, 10'd5, 9'd4, 12'h0A5, 1'b0);
    checks++; if (wa.size() != 2) $display("FAIL clip_count got=%0d exp=2", wa.size()); else passes++;
    if (wa.size() >= 2) begin
      checks++; if (wa[0] !== 19'd307198) $display("FAIL clip_addr0 got=%0d exp=307198", wa[0]); else passes++;
      checks++; if (wa[1] !== 19'd307199) $display("FAIL clip_addr1 got=%0d exp=307199", wa[1]); else passes++;
      checks++; if (wd[1] !== 12'h0A5) $display("FAIL clip_dout got=%h exp=0A5", wd[1]); else passes++;
    end
    checks++; if (done_cyc != 3) $display("FAIL clip_done_cycle got=%0d exp=3", done_cyc); else passes++;
  endtask

  task automatic test_empty();
    run_cmd(10'd5, 9'd5, 10'd0, 9'd3, 12'hFFF, 1'b0);
    checks++; if (wa.size() != 0) $display("FAIL empty_w0_count got=%0d exp=0", wa.size()); else passes++;
    checks++; if (done_cyc != 2) $display("FAIL empty_w0_done_cycle got=%0d exp=2", done_cyc); else passes++;
    run_cmd(10'd700, 9'd0, 10'd5, 9'd1, 12'hFFF, 1'b0);
    checks++; if (wa.size() != 0) $display("FAIL offscreen_count got=%0d exp=0", wa.size()); else passes++;
    checks++; if (done_cyc != 2) $display("FAIL offscreen_done_cycle got=%0d exp=2", done_cyc); else passes++;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL offscreen_idle_busy got=%b exp=0", busy); else passes++;
  endtask

  task automatic test_start_while_busy();
    int nw = 0;
    int nd = 0;
    logic [18:0] last_a = '0;
    @(negedge clk);
    x0 = 10'd10; y0 = 9'd20; w = 10'd3; h = 9'd2; color = 12'h0F0; outline = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (we) begin nw++; last_a = addr; end
      if (done) nd++;
      if (c == 3) begin
        start = 1'b1; x0 = 10'd0; y0 = 9'd0; w = 10'd5; h = 9'd5;
      end else begin
        start = 1'b0;
      end
    end
    checks++; if (nw != 6) $display("FAIL busy_start_count got=%0d exp=6", nw); else passes++;
    checks++; if (last_a !== 19'd13452) $display("FAIL busy_start_last_addr got=%0d exp=13452", last_a); else passes++;
    checks++; if (nd != 1) $display("FAIL busy_start_done_count got=%0d exp=1", nd); else passes++;
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    x0 = 10'd0; y0 = 9'd0; w = 10'd10; h = 9'd10; color = 12'h123; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (we !== 1'b1) $display("FAIL midrst_pre_we got=%b exp=1", we); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (we !== 1'b0) $display("FAIL midrst_we got=%b exp=0", we); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else passes++;
    @(negedge clk);
    rst = 1'b0;
    run_cmd(10'd10, 9'd20, 10'd3, 9'd2, 12'hF00, 1'b0);
    checks++; if (wa.size() != 6) $display("FAIL midrst_after_count got=%0d exp=6", wa.size()); else passes++;
    checks++; if (done_cyc != 7) $display("FAIL midrst_after_done got=%0d exp=7", done_cyc); else passes++;
  endtask

  task automatic test_back_to_back();
    int nw = 0;
    int dcyc[$];
    int rise[$];
    logic prev_busy;
    @(negedge clk);
    @(negedge clk);
    x0 = 10'd1; y0 = 9'd1; w = 10'd2; h = 9'd1; color = 12'h00F; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    prev_busy = busy;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (we) nw++;
      if (done) dcyc.push_back(c);
      if (busy && !prev_busy) rise.push_back(c);
      prev_busy = busy;
      if (c == 14) start = 1'b0;
    end
    checks++; if (nw != 6) $display("FAIL b2b_writes got=%0d exp=6", nw); else passes++;
    checks++;
    if (dcyc.size() != 3 || dcyc[0] != 3 || dcyc[1] != 8 || dcyc[2] != 13)
      $display("FAIL b2b_done_cycles got=%p exp=3,8,13", dcyc);
    else passes++;
    checks++;
    if (rise.size() != 2 || rise[0] != 5 || rise[1] != 10)
      $display("FAIL b2b_busy_rise got=%p exp=5,10", rise);
    else passes++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_outline();
`ifdef RECT_FILL_OUTLINE_EN
    logic [18:0] ea [10] = '{19'd0, 19'd1, 19'd2, 19'd3, 19'd640, 19'd643,
                             19'd1280, 19'd1281, 19'd1282, 19'd1283};
    int n = 10;
`else
    logic [18:0] ea [12] = '{19'd0, 19'd1, 19'd2, 19'd3, 19'd640, 19'd641, 19'd642, 19'd643,
                             19'd1280, 19'd1281, 19'd1282, 19'd1283};
    int n = 12;
`endif
    run_cmd(10'd0, 9'd0, 10'd4, 9'd3, 12'hABC, 1'b1);
    checks++; if (wa.size() != n) $display("FAIL outline_count got=%0d exp=%0d", wa.size(), n); else passes++;
    for (int i = 0; i < n && i < wa.size(); i++) begin
      checks++; if (wa[i] !== ea[i]) $display("FAIL outline_addr[%0d] got=%0d exp=%0d", i, wa[i], ea[i]); else passes++;
    end
    checks++; if (done_cyc != 13) $display("FAIL outline_done_cycle got=%0d exp=13", done_cyc); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_empty();
    test_start_while_busy();
    test_mid_reset();
    test_back_to_back();
    test_outline();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
